// File: rtl/uart_rx_cfg_if.sv
// Consumer-side bundle of the configurable UART receiver:
// FIFO pop, error clear, head word, FIFO status and sticky error flags.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
);
    logic            rd_uart;
    logic            err_clr;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;
    logic            parity_err;
    logic            frame_err;
    logic            overrun_err;

    modport master (
        output rd_uart, err_clr,
        input  r_data, rx_empty, rx_full,
        input  parity_err, frame_err, overrun_err
    );

    modport slave (
        input  rd_uart, err_clr,
        output r_data, rx_empty, rx_full,
        output parity_err, frame_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop rx synchroniser, oversampling
// frame FSM, optional parity, FWFT receive FIFO and sticky error flags.
module uart_rx_cfg #(
    parameter int DBIT     = 8,
    parameter int PARITY   = 0,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8,
    parameter int FIFO_W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    uart_rx_cfg_if.slave bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam int SW    = (SB_TICK > 16) ? 5 : 4;
    localparam int NW    = $clog2(DBIT);
    localparam int DEPTH = 2 ** FIFO_W;

    localparam logic [SW-1:0]       S_MID   = SW'(7);
    localparam logic [SW-1:0]       S_END   = SW'(15);
    localparam logic [SW-1:0]       S_STOP  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0]       N_LAST  = NW'(DBIT - 1);
    localparam logic [DVSR_BIT-1:0] CNT_MAX = DVSR_BIT'(DVSR - 1);
    localparam logic [FIFO_W:0]     CNT_FUL = (FIFO_W + 1)'(DEPTH);

    logic                rx_meta_q, rx_meta_d;
    logic                rx_sync_q, rx_sync_d;
    logic [DVSR_BIT-1:0] cnt_q, cnt_d;
    state_t              state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic                p_q, p_d;
    logic [FIFO_W-1:0]   wptr_q, wptr_d;
    logic [FIFO_W-1:0]   rptr_q, rptr_d;
    logic [FIFO_W:0]     count_q, count_d;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                ovr_err_q, ovr_err_d;
    logic [DBIT-1:0]     mem_q [DEPTH];

    logic tick;
    logic frame_done;
    logic par_bad;
    logic empty;
    logic full;
    logic rd_en;
    logic wr_en;
    logic set_par;
    logic set_frm;
    logic set_ovr;

    // Baud generator, synchroniser and FIFO/flag next values
    always_comb begin
        tick      = (cnt_q == CNT_MAX);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;

        empty  = (count_q == '0);
        full   = (count_q == CNT_FUL);
        rd_en  = bus.rd_uart && !empty;
        wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        par_err_d = (par_err_q & ~bus.err_clr) | set_par;
        frm_err_d = (frm_err_q & ~bus.err_clr) | set_frm;
        ovr_err_d = (ovr_err_q & ~bus.err_clr) | set_ovr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            p_q       <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            p_q       <= p_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wptr_q] <= b_q;
        end
    end

    // Frame FSM next state; ticks counted in s, bits in n
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_END) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    if (s_q == S_END) begin
                        s_d     = '0;
                        p_d     = rx_sync_q;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame evaluation: parity beats framing beats overrun
    always_comb begin
        frame_done = (state_q == STOP) && tick && (s_q == S_STOP);
        par_bad    = (PARITY != 0) &&
                     ((^b_q ^ p_q) != (PARITY == 2));
        set_par    = frame_done && par_bad;
        set_frm    = frame_done && !par_bad && !rx_sync_q;
        set_ovr    = frame_done && !par_bad && rx_sync_q &&
                     full && !rd_en;
        wr_en      = frame_done && !par_bad && rx_sync_q &&
                     !(full && !rd_en);
    end

    assign bus.r_data      = empty ? '0 : mem_q[rptr_q];
    assign bus.rx_empty    = empty;
    assign bus.rx_full     = full;
    assign bus.parity_err  = par_err_q;
    assign bus.frame_err   = frm_err_q;
    assign bus.overrun_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg (8E1, DVSR=4, 4-deep FIFO): frame-level model
// of FIFO contents and sticky flags, checked every settled cycle.
module tb_uart_rx_cfg;

    localparam int BT = 64;

    logic clk = 1'b0;
    logic reset;
    logic rx;

    uart_rx_cfg_if #(.DBIT(8)) bus ();

    uart_rx_cfg #(
        .DBIT    (8),
        .PARITY  (1),
        .SB_TICK (16),
        .DVSR    (4),
        .DVSR_BIT(2),
        .FIFO_W  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    byte unsigned mq[$];
    bit  m_par, m_frm, m_ovr;
    bit  settled;
    int  vectors;
    int  miscompares;
    int  shown;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic compare();
        logic [12:0] act;
        logic [12:0] exp;
        bit          e;
        e   = (mq.size() == 0);
        exp = {e ? 8'h00 : mq[0], e, mq.size() == 4,
               m_par, m_frm, m_ovr};
        act = {e ? 8'h00 : bus.r_data, bus.rx_empty, bus.rx_full,
               bus.parity_err, bus.frame_err, bus.overrun_err};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (shown < 20) begin
                shown++;
                $display("FAIL cycle_cmp @%0t: got {data,emp,ful,par,frm,ovr}=%h, want %h",
                         $time, act, exp);
            end
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input bit pbad,
                               input bit slow);
        if (pbad) m_par = 1'b1;
        else if (slow) m_frm = 1'b1;
        else if (mq.size() == 4) m_ovr = 1'b1;
        else mq.push_back(d);
    endtask

    // Outputs only move at the stop-bit sample, so checking is
    // suspended only while the stop bit is on the line.
    task automatic send_frame(input logic [7:0] d, input bit pbad,
                              input bit slow, input bit clr);
        bit seen;
        seen = 1'b0;
        rx = 1'b0;
        repeat (BT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BT) @(posedge clk);
            #1;
        end
        rx = (^d) ^ pbad;
        repeat (BT) @(posedge clk);
        #1;
        settled = 1'b0;
        if (clr) bus.err_clr = 1'b1;
        for (int k = 0; k < BT; k++) begin
            rx = (slow && k < 40) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (bus.err_clr && bus.parity_err) begin
                bus.err_clr = 1'b0;
                seen = 1'b1;
            end
        end
        if (clr) begin
            bus.err_clr = 1'b0;
            chk("clr_vs_set", 8'(seen), 8'd1);
            m_par = 1'b0;
            m_frm = 1'b0;
            m_ovr = 1'b0;
        end
        rx = 1'b1;
        model_frame(d, pbad, slow);
        settled = 1'b1;
        repeat (32) @(posedge clk);
        #1;
    endtask

    task automatic do_read();
        settled = 1'b0;
        bus.rd_uart = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_uart = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        settled = 1'b1;
    endtask

    task automatic do_clear();
        settled = 1'b0;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        settled = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        int         kind;
        reset       = 1'b1;
        rx          = 1'b1;
        bus.rd_uart = 1'b0;
        bus.err_clr = 1'b0;
        settled     = 1'b0;
        vectors     = 0;
        miscompares = 0;
        shown       = 0;
        m_par       = 1'b0;
        m_frm       = 1'b0;
        m_ovr       = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (settled) compare();
            end
        join_none

        idle(4);
        reset = 1'b0;
        chk("rst_empty", 8'(bus.rx_empty), 8'd1);
        chk("rst_full", 8'(bus.rx_full), 8'd0);
        chk("rst_flags", {5'd0, bus.parity_err, bus.frame_err,
                          bus.overrun_err}, 8'd0);
        chk("rst_rdata", bus.r_data, 8'h00);
        settled = 1'b1;
        idle(10);

        send_frame(8'h41, 1'b0, 1'b0, 1'b0);
        chk("a_data", bus.r_data, 8'h41);
        chk("a_empty", 8'(bus.rx_empty), 8'd0);
        do_read();
        chk("a_pop", 8'(bus.rx_empty), 8'd1);

        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        chk("par_set", 8'(bus.parity_err), 8'd1);
        chk("par_nowr", 8'(bus.rx_empty), 8'd1);
        do_clear();
        chk("par_clr", 8'(bus.parity_err), 8'd0);

        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        chk("frm_set", 8'(bus.frame_err), 8'd1);
        chk("frm_nowr", 8'(bus.rx_empty), 8'd1);
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        chk("b_data", bus.r_data, 8'h42);
        do_read();

        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(BT);
        chk("glitch_empty", 8'(bus.rx_empty), 8'd1);

        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b0, 1'b0, 1'b0);
            if (v == 4) chk("full4", 8'(bus.rx_full), 8'd1);
            if (v == 4) chk("novr4", 8'(bus.overrun_err), 8'd0);
        end
        chk("ovr5", 8'(bus.overrun_err), 8'd1);
        for (int v = 1; v <= 4; v++) begin
            chk("fifo_order", bus.r_data, 8'(v));
            do_read();
        end
        chk("drained", 8'(bus.rx_empty), 8'd1);

        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        chk("race_par", 8'(bus.parity_err), 8'd1);
        chk("race_frm", 8'(bus.frame_err), 8'd0);
        chk("race_ovr", 8'(bus.overrun_err), 8'd0);

        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        d  = 8'h3C;
        rx = 1'b0;
        idle(BT);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            idle(BT);
        end
        rx = d[3];
        idle(20);
        settled = 1'b0;
        reset = 1'b1;
        rx = 1'b1;
        idle(1);
        reset = 1'b0;
        mq.delete();
        m_par = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        chk("mid_rst_empty", 8'(bus.rx_empty), 8'd1);
        chk("mid_rst_par", 8'(bus.parity_err), 8'd0);
        chk("mid_rst_rdata", bus.r_data, 8'h00);
        settled = 1'b1;
        idle(BT);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("post_rst", bus.r_data, 8'hA5);
        do_read();

        for (int f = 0; f < 40; f++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            send_frame(d, kind == 0, kind == 1, 1'b0);
            repeat ($urandom_range(0, 2)) do_read();
            if ($urandom_range(0, 7) == 0) do_clear();
            idle(int'($urandom_range(1, 20)));
        end
        while (mq.size() != 0) do_read();
        do_read();
        idle(4);

        settled = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
